// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the multi-cycle data memory.
package dmem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DEFAULT_READ_WAIT  = 3;
  localparam int DEFAULT_WRITE_WAIT = 2;

  // Wide enough to hold the larger of the two wait counts.
  function automatic int cnt_width(input int read_wait, input int write_wait);
    int max_wait;
    max_wait = (read_wait > write_wait) ? read_wait : write_wait;
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous byte-enabled write, combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 64,
  parameter string INIT_FILE = "",
  localparam int   IDX_W     = $clog2(DEPTH),
  localparam int   NB        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NB-1:0]     be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents survive reset on purpose, so there is no reset branch here.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_multicycle.sv
// Multi-cycle data memory: request latch, wait-state counter and
// registered completion outputs in front of a dmem_array.
module dmem_multicycle
  import dmem_pkg::*;
#(
  parameter int    DATA_W     = 32,
  parameter int    ADDR_W     = 32,
  parameter int    DEPTH      = 64,
  parameter int    READ_WAIT  = DEFAULT_READ_WAIT,
  parameter int    WRITE_WAIT = DEFAULT_WRITE_WAIT,
  parameter string INIT_FILE  = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mstrobe,
  input  logic                r_w,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   mem_out,
  output logic                mem_ready,
  output logic                mem_busy,
  output logic                addr_err
);

  localparam int CNT_W = cnt_width(READ_WAIT, WRITE_WAIT);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = DATA_W / 8;

  localparam logic [CNT_W-1:0]  RD_LOAD    = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0]  WR_LOAD    = CNT_W'(WRITE_WAIT - 1);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(DEPTH * 4);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                rw_q;
  logic [NB-1:0]       be_q;
  logic                capture;
  logic                done;
  logic                in_range;
  logic [DATA_W-1:0]   rdata;

  assign in_range = ({1'b0, addr_q} < ADDR_LIMIT);
  assign mem_busy = (state_q == BUSY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mstrobe) begin
          capture = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // Completion outputs are registered, so they appear with state already IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rw_q      <= 1'b0;
      be_q      <= '0;
      mem_out   <= '0;
      mem_ready <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      mem_ready <= done;
      addr_err  <= done && !in_range;
      if (capture) begin
        addr_q <= mem_addr;
        data_q <= mem_data;
        rw_q   <= r_w;
        be_q   <= byte_en;
        cnt_q  <= r_w ? WR_LOAD : RD_LOAD;
      end else if (mem_busy && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (done && !rw_q) mem_out <= in_range ? rdata : '0;
    end
  end

  dmem_array #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .we    (done && rw_q && in_range),
    .be    (be_q),
    .idx   (addr_q[IDX_W+1:2]),
    .wdata (data_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_dmem_multicycle.sv
// Self-checking bench for dmem_multicycle: directed scenarios plus random
// traffic compared against a word-array reference model.
module tb_dmem_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mstrobe = 1'b0;
  logic        r_w = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic [3:0]  byte_en = '0;
  logic [31:0] mem_out;
  logic        mem_ready, mem_busy, addr_err;

  logic        s_mstrobe = 1'b0;
  logic        s_rw = 1'b0;
  logic [31:0] s_addr = '0;
  logic [63:0] s_data = '0;
  logic [7:0]  s_be = '0;
  logic [63:0] s_out;
  logic        s_ready, s_busy, s_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [64];
  logic [31:0] ref_out = '0;

  always #5 clk = ~clk;

  dmem_multicycle u_dut (
    .clk(clk), .reset(reset), .mstrobe(mstrobe), .r_w(r_w),
    .mem_addr(mem_addr), .mem_data(mem_data), .byte_en(byte_en),
    .mem_out(mem_out), .mem_ready(mem_ready), .mem_busy(mem_busy),
    .addr_err(addr_err)
  );

  dmem_multicycle #(.DATA_W(64), .DEPTH(16), .READ_WAIT(1)) u_dut64 (
    .clk(clk), .reset(reset), .mstrobe(s_mstrobe), .r_w(s_rw),
    .mem_addr(s_addr), .mem_data(s_data), .byte_en(s_be),
    .mem_out(s_out), .mem_ready(s_ready), .mem_busy(s_busy),
    .addr_err(s_err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to completion; returns #1 after the
  // completion edge, i.e. inside the mem_ready cycle.
  task automatic applyStimulus(input bit rw, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] be, input bit poke);
    int  n;
    int  word;
    bit  in_rng;
    mem_addr = addr; mem_data = data; byte_en = be; r_w = rw; mstrobe = 1'b1;
    @(posedge clk); #1;
    checkOutput("capture_busy", 64'(mem_busy), 64'(1));
    checkOutput("capture_ready", 64'(mem_ready), 64'(0));
    if (poke) begin
      mem_addr = addr ^ 32'h4; mem_data = ~data; r_w = ~rw; byte_en = ~be;
    end else begin
      mstrobe = 1'b0;
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) mstrobe = 1'b0;
      if (!mem_ready && n < 20) checkOutput("wait_busy", 64'(mem_busy), 64'(1));
    end while (!mem_ready && n < 20);
    checkOutput("latency", 64'(n), 64'(rw ? 2 : 3));
    in_rng = (addr < 32'd256);
    word   = int'(addr[7:2]);
    if (rw) begin
      if (in_rng)
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[word][b*8 +: 8] = data[b*8 +: 8];
    end else begin
      ref_out = in_rng ? ref_mem[word] : 32'h0;
    end
    checkOutput("mem_out", 64'(mem_out), 64'(ref_out));
    checkOutput("addr_err", 64'(addr_err), 64'(!in_rng));
    checkOutput("done_busy", 64'(mem_busy), 64'(0));
  endtask

  task automatic idleCheck();
    mstrobe = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_ready", 64'(mem_ready), 64'(0));
    checkOutput("idle_busy", 64'(mem_busy), 64'(0));
    checkOutput("idle_err", 64'(addr_err), 64'(0));
  endtask

  initial begin
    logic [31:0] prior;
    logic [63:0] wide;
    int          word;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out", 64'(mem_out), 64'(0));
    checkOutput("rst_ready", 64'(mem_ready), 64'(0));
    checkOutput("rst_busy", 64'(mem_busy), 64'(0));
    checkOutput("rst_err", 64'(addr_err), 64'(0));
    checkOutput("rst_out64", s_out, 64'(0));
    reset = 1'b0;

    $display("[TB] filling all words back-to-back");
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 32'(i * 4), $urandom, 4'hf, 1'b0);
    idleCheck();

    $display("[TB] write then read");
    applyStimulus(1'b1, 32'h20, 32'h302fcaaa, 4'hf, 1'b0);
    idleCheck();
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    checkOutput("wr_rd_value", 64'(mem_out), 64'h302fcaaa);
    idleCheck();

    $display("[TB] byte-enabled write");
    applyStimulus(1'b1, 32'h24, 32'h0, 4'hf, 1'b0);
    applyStimulus(1'b1, 32'h24, 32'hdeadbeef, 4'b0101, 1'b0);
    applyStimulus(1'b0, 32'h24, 32'h0, 4'h0, 1'b0);
    checkOutput("byte_en_value", 64'(mem_out), 64'h00ad00ef);
    idleCheck();

    $display("[TB] out-of-range access");
    applyStimulus(1'b1, 32'h100, 32'hcafef00d, 4'hf, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    applyStimulus(1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
    checkOutput("oor_read_zero", 64'(mem_out), 64'(0));
    idleCheck();

    $display("[TB] strobe while busy");
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    checkOutput("poke_value", 64'(mem_out), 64'h302fcaaa);
    idleCheck();

    $display("[TB] back-to-back reads");
    applyStimulus(1'b0, 32'h24, 32'h0, 4'h0, 1'b0);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    idleCheck();

    $display("[TB] reset during write");
    prior = ref_mem[10];
    mem_addr = 32'h28; mem_data = 32'h11111111; byte_en = 4'hf; r_w = 1'b1; mstrobe = 1'b1;
    @(posedge clk); #1;
    mstrobe = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    ref_out = 32'h0;
    checkOutput("abort_out", 64'(mem_out), 64'(0));
    checkOutput("abort_busy", 64'(mem_busy), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("abort_ready", 64'(mem_ready), 64'(0));
    end
    reset = 1'b0;
    applyStimulus(1'b0, 32'h28, 32'h0, 4'h0, 1'b0);
    checkOutput("abort_prior", 64'(mem_out), 64'(prior));
    idleCheck();

    $display("[TB] random traffic");
    for (int t = 0; t < 60; t++) begin
      word = $urandom_range(0, 71);
      applyStimulus(1'($urandom_range(0, 1)), 32'(word * 4 + $urandom_range(0, 3)),
                    $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) idleCheck();
    end
    idleCheck();

    $display("[TB] 64-bit, 16-deep, single read wait");
    wide = {$urandom, $urandom};
    s_addr = 32'h8; s_data = wide; s_be = 8'hff; s_rw = 1'b1; s_mstrobe = 1'b1;
    @(posedge clk); #1;
    s_mstrobe = 1'b0;
    checkOutput("w64_busy", 64'(s_busy), 64'(1));
    @(posedge clk); #1;
    checkOutput("w64_ready_early", 64'(s_ready), 64'(0));
    @(posedge clk); #1;
    checkOutput("w64_ready", 64'(s_ready), 64'(1));
    checkOutput("w64_out_kept", s_out, 64'(0));
    s_rw = 1'b0; s_data = '0; s_mstrobe = 1'b1;
    @(posedge clk); #1;
    s_mstrobe = 1'b0;
    checkOutput("r64_ready_early", 64'(s_ready), 64'(0));
    @(posedge clk); #1;
    checkOutput("r64_ready", 64'(s_ready), 64'(1));
    checkOutput("r64_err", 64'(s_err), 64'(0));
    checkOutput("r64_value", s_out, wide);
    @(posedge clk); #1;
    checkOutput("r64_pulse", 64'(s_ready), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
